// File: rtl/etapa_ex_mem.sv
// EX/MEM pipeline register: resolves branches, selects the write-back register and
// presents registered MEM-stage controls with stall/flush and a saturating taken-branch count.
module etapa_ex_mem #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [9:0]        Controls1,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] dato_escr_in,
  input  logic [DATA_W-1:0] pc_salto_in,
  input  logic [DATA_W-1:0] pc_jump_in,
  output logic              valid_out,
  output logic              MemaReg_o,
  output logic              EscrReg_o,
  output logic              LeerMem_o,
  output logic              EscrMem_o,
  output logic [DATA_W-1:0] alu_res_o,
  output logic [DATA_W-1:0] dato_escr_o,
  output logic [REG_W-1:0]  reg_dest_o,
  output logic              PCSrc_o,
  output logic [DATA_W-1:0] pc_destino_o,
  output logic [CNT_W-1:0]  cnt_saltos_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_d,    valid_q;
  logic              memareg_d,  memareg_q;
  logic              escrreg_d,  escrreg_q;
  logic              leermem_d,  leermem_q;
  logic              escrmem_d,  escrmem_q;
  logic [DATA_W-1:0] alu_res_d,  alu_res_q;
  logic [DATA_W-1:0] dato_d,     dato_q;
  logic [REG_W-1:0]  reg_dest_d, reg_dest_q;
  logic              pcsrc_d,    pcsrc_q;
  logic [DATA_W-1:0] pc_dest_d,  pc_dest_q;
  logic [CNT_W-1:0]  cnt_d,      cnt_q;
  logic              taken_s;

  // FuenteALU and ALUOp are consumed upstream in EX and intentionally dropped here
  logic unused_ctrl_s;
  assign unused_ctrl_s = ^{Controls1[7], Controls1[1:0]};

  // Next-state selection: flush > stall > capture
  always_comb begin
    taken_s    = valid_in & (Controls1[9] | (Controls1[2] & zero_in));
    valid_d    = valid_q;
    memareg_d  = memareg_q;
    escrreg_d  = escrreg_q;
    leermem_d  = leermem_q;
    escrmem_d  = escrmem_q;
    alu_res_d  = alu_res_q;
    dato_d     = dato_q;
    reg_dest_d = reg_dest_q;
    pcsrc_d    = pcsrc_q;
    pc_dest_d  = pc_dest_q;
    cnt_d      = cnt_q;
    if (flush) begin
      valid_d    = 1'b0;
      memareg_d  = 1'b0;
      escrreg_d  = 1'b0;
      leermem_d  = 1'b0;
      escrmem_d  = 1'b0;
      alu_res_d  = {DATA_W{1'b0}};
      dato_d     = {DATA_W{1'b0}};
      reg_dest_d = {REG_W{1'b0}};
      pcsrc_d    = 1'b0;
      pc_dest_d  = {DATA_W{1'b0}};
    end else if (stall) begin
      // holding the pulse would re-redirect the PC on every stalled cycle
      pcsrc_d = 1'b0;
    end else begin
      valid_d    = valid_in;
      memareg_d  = Controls1[6] & valid_in;
      escrreg_d  = Controls1[5] & valid_in;
      leermem_d  = Controls1[4] & valid_in;
      escrmem_d  = Controls1[3] & valid_in;
      alu_res_d  = alu_res_in;
      dato_d     = dato_escr_in;
      reg_dest_d = Controls1[8] ? rd_in : rt_in;
      pcsrc_d    = taken_s;
      pc_dest_d  = Controls1[9] ? pc_jump_in : pc_salto_in;
      if (taken_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      memareg_q  <= 1'b0;
      escrreg_q  <= 1'b0;
      leermem_q  <= 1'b0;
      escrmem_q  <= 1'b0;
      alu_res_q  <= {DATA_W{1'b0}};
      dato_q     <= {DATA_W{1'b0}};
      reg_dest_q <= {REG_W{1'b0}};
      pcsrc_q    <= 1'b0;
      pc_dest_q  <= {DATA_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      valid_q    <= valid_d;
      memareg_q  <= memareg_d;
      escrreg_q  <= escrreg_d;
      leermem_q  <= leermem_d;
      escrmem_q  <= escrmem_d;
      alu_res_q  <= alu_res_d;
      dato_q     <= dato_d;
      reg_dest_q <= reg_dest_d;
      pcsrc_q    <= pcsrc_d;
      pc_dest_q  <= pc_dest_d;
      cnt_q      <= cnt_d;
    end
  end

  assign valid_out    = valid_q;
  assign MemaReg_o    = memareg_q;
  assign EscrReg_o    = escrreg_q;
  assign LeerMem_o    = leermem_q;
  assign EscrMem_o    = escrmem_q;
  assign alu_res_o    = alu_res_q;
  assign dato_escr_o  = dato_q;
  assign reg_dest_o   = reg_dest_q;
  assign PCSrc_o      = pcsrc_q;
  assign pc_destino_o = pc_dest_q;
  assign cnt_saltos_o = cnt_q;

endmodule

// File: tb/tb_etapa_ex_mem.sv
// Randomized bench for etapa_ex_mem against a behavioural model, plus directed literal
// checks; a second instance with a 2-bit counter exercises saturation.
module tb_etapa_ex_mem;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in, zero_in;
  logic [9:0]  Controls1;
  logic [4:0]  rt_in, rd_in;
  logic [31:0] alu_res_in, dato_escr_in, pc_salto_in, pc_jump_in;

  logic        valid_out, MemaReg_o, EscrReg_o, LeerMem_o, EscrMem_o, PCSrc_o;
  logic [31:0] alu_res_o, dato_escr_o, pc_destino_o;
  logic [4:0]  reg_dest_o;
  logic [15:0] cnt_saltos_o;

  logic        v2, mr2, er2, lm2, em2, pc2;
  logic [31:0] alu2, dato2, pcd2;
  logic [4:0]  rd2;
  logic [1:0]  cnt2_o;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic        m_valid, m_mr, m_er, m_lm, m_em, m_pcsrc;
  logic [31:0] m_alu, m_dato, m_pcdest;
  logic [4:0]  m_rd;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  etapa_ex_mem #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .Controls1(Controls1), .rt_in(rt_in), .rd_in(rd_in), .alu_res_in(alu_res_in),
    .zero_in(zero_in), .dato_escr_in(dato_escr_in), .pc_salto_in(pc_salto_in),
    .pc_jump_in(pc_jump_in), .valid_out(valid_out), .MemaReg_o(MemaReg_o),
    .EscrReg_o(EscrReg_o), .LeerMem_o(LeerMem_o), .EscrMem_o(EscrMem_o),
    .alu_res_o(alu_res_o), .dato_escr_o(dato_escr_o), .reg_dest_o(reg_dest_o),
    .PCSrc_o(PCSrc_o), .pc_destino_o(pc_destino_o), .cnt_saltos_o(cnt_saltos_o)
  );

  etapa_ex_mem #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .Controls1(Controls1), .rt_in(rt_in), .rd_in(rd_in), .alu_res_in(alu_res_in),
    .zero_in(zero_in), .dato_escr_in(dato_escr_in), .pc_salto_in(pc_salto_in),
    .pc_jump_in(pc_jump_in), .valid_out(v2), .MemaReg_o(mr2),
    .EscrReg_o(er2), .LeerMem_o(lm2), .EscrMem_o(em2),
    .alu_res_o(alu2), .dato_escr_o(dato2), .reg_dest_o(rd2),
    .PCSrc_o(pc2), .pc_destino_o(pcd2), .cnt_saltos_o(cnt2_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the stage must hold after this edge
  task automatic model_step();
    bit taken;
    if (rst) begin
      {m_valid, m_mr, m_er, m_lm, m_em, m_pcsrc} = 6'b0;
      m_alu = 0; m_dato = 0; m_pcdest = 0; m_rd = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (flush) begin
      {m_valid, m_mr, m_er, m_lm, m_em, m_pcsrc} = 6'b0;
      m_alu = 0; m_dato = 0; m_pcdest = 0; m_rd = 0;
    end else if (stall) begin
      m_pcsrc = 1'b0;
    end else begin
      taken   = valid_in && (Controls1[9] || (Controls1[2] && zero_in));
      m_valid = valid_in;
      m_mr    = valid_in && Controls1[6];
      m_er    = valid_in && Controls1[5];
      m_lm    = valid_in && Controls1[4];
      m_em    = valid_in && Controls1[3];
      m_alu   = alu_res_in;
      m_dato  = dato_escr_in;
      m_rd    = Controls1[8] ? rd_in : rt_in;
      m_pcsrc = taken;
      m_pcdest = Controls1[9] ? pc_jump_in : pc_salto_in;
      if (taken) begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
        m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
      end
    end
  endtask

  task automatic check_model();
    chk("valid_out", valid_out, m_valid);
    chk("MemaReg",   MemaReg_o, m_mr);
    chk("EscrReg",   EscrReg_o, m_er);
    chk("LeerMem",   LeerMem_o, m_lm);
    chk("EscrMem",   EscrMem_o, m_em);
    chk("alu_res",   alu_res_o, m_alu);
    chk("dato_escr", dato_escr_o, m_dato);
    chk("reg_dest",  reg_dest_o, m_rd);
    chk("PCSrc",     PCSrc_o, m_pcsrc);
    chk("pc_destino", pc_destino_o, m_pcdest);
    chk("cnt_saltos", cnt_saltos_o, m_cnt);
    chk("cnt_saltos_w2", cnt2_o, m_cnt2);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic rand_inputs();
    Controls1    = 10'($urandom);
    rt_in        = 5'($urandom);
    rd_in        = 5'($urandom);
    alu_res_in   = $urandom;
    dato_escr_in = $urandom;
    pc_salto_in  = $urandom;
    pc_jump_in   = $urandom;
    zero_in      = 1'($urandom);
    valid_in     = 1'($urandom);
  endtask

  initial begin
    rand_inputs();
    // T1: reset dominates stall and flush
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    cycle(); cycle();
    chk("T1 valid_out", valid_out, 1'b0);
    chk("T1 PCSrc", PCSrc_o, 1'b0);
    chk("T1 cnt", cnt_saltos_o, 16'd0);
    chk("T1 pc_destino", pc_destino_o, 32'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    // T2: load (FuenteALU, MemaReg, EscrReg, LeerMem)
    rand_inputs();
    Controls1 = 10'b00_1111_0000; rt_in = 5'd7; alu_res_in = 32'h40; valid_in = 1'b1;
    cycle();
    chk("T2 LeerMem", LeerMem_o, 1'b1);
    chk("T2 EscrReg", EscrReg_o, 1'b1);
    chk("T2 MemaReg", MemaReg_o, 1'b1);
    chk("T2 reg_dest", reg_dest_o, 5'd7);
    chk("T2 alu_res", alu_res_o, 32'h40);
    chk("T2 PCSrc", PCSrc_o, 1'b0);

    // T3: beq taken, then not taken
    rand_inputs();
    Controls1 = 10'b00_0000_0100; zero_in = 1'b1; pc_salto_in = 32'h100; valid_in = 1'b1;
    cycle();
    chk("T3 PCSrc", PCSrc_o, 1'b1);
    chk("T3 pc_destino", pc_destino_o, 32'h100);
    chk("T3 cnt", cnt_saltos_o, 16'd1);
    zero_in = 1'b0;
    cycle();
    chk("T3 PCSrc nt", PCSrc_o, 1'b0);
    chk("T3 cnt nt", cnt_saltos_o, 16'd1);

    // T4: R-type held through a 3-cycle stall
    rand_inputs();
    Controls1 = 10'b01_0010_0010; rd_in = 5'd3; valid_in = 1'b1;
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle();
      chk("T4 reg_dest", reg_dest_o, 5'd3);
      chk("T4 EscrReg", EscrReg_o, 1'b1);
    end
    stall = 1'b0;
    // T4b: jump captured right before a stall pulses and counts once
    rand_inputs();
    Controls1 = 10'b10_0000_0100; valid_in = 1'b1; pc_jump_in = 32'h2000;
    cycle();
    chk("T4 jump PCSrc", PCSrc_o, 1'b1);
    chk("T4 jump dest", pc_destino_o, 32'h2000);
    chk("T4 jump cnt", cnt_saltos_o, 16'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle();
      chk("T4 stall PCSrc", PCSrc_o, 1'b0);
      chk("T4 stall cnt", cnt_saltos_o, 16'd2);
    end

    // T5: flush wins over stall
    rand_inputs();
    Controls1 = 10'b00_0000_1000; valid_in = 1'b1; flush = 1'b1;
    cycle();
    chk("T5 EscrMem", EscrMem_o, 1'b0);
    chk("T5 valid_out", valid_out, 1'b0);
    chk("T5 cnt", cnt_saltos_o, 16'd2);
    stall = 1'b0; flush = 1'b0;

    // T6: 2-bit counter saturates
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      Controls1[9] = 1'b1; valid_in = 1'b1;
      cycle();
      chk("T6 cnt2", cnt2_o, (i < 3) ? 2'(i + 1) : 2'd3);
    end

    // Random phase
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
